imem_fetch_responder: RTL and testbench
=======================================

// Module: imem_fetch_responder
// PURPOSE
//  Instruction-memory side of the IFetcher fetch port: returns the 64-bit little-endian window of
//  instruction bytes starting at byte {haddr,1'b0}. The window is assembled from a 32-bit
//  synchronous-read instruction RAM, 2 beats if word-aligned, 3 beats if halfword-offset.
//  Sits between IFetcher (mem_i consumer) and the instruction RAM; flush_i is driven by branch redirect.
// PARAMETERS
//  PC_W    25  halfword-address width (matches IFetcher PC_o)
//  WA_W    24  RAM word-address width; fixed at PC_W-1, wraps modulo 2^WA_W
// PORTS
//  clk        in   1     single clock, all state on posedge
//  rst_n      in   1     asynchronous, active-low reset
//  flush_i    in   1     abort any in-flight fetch
//  req_valid  in   1     fetch request present
//  req_haddr  in   PC_W  halfword address of window start (PC + next_fetch)
//  req_ready  out  1     request accepted when req_valid & req_ready
//  rsp_valid  out  1     rsp_data holds the requested window
//  rsp_ready  in   1     consumer takes response when rsp_valid & rsp_ready
//  rsp_data   out  64    bytes [B+7:B], B = {haddr,1'b0}, byte B in bits [7:0]
//  rsp_haddr  out  PC_W  echo of accepted req_haddr
//  mem_rd     out  1     RAM read strobe
//  mem_addr   out  WA_W  RAM word address
//  mem_rdata  in   32    RAM data, valid the cycle after mem_rd
// BEHAVIOUR
//  Reset (async): state IDLE, rsp_valid=0, rsp_data=0, rsp_haddr=0, mem_rd=0, mem_addr=0, buffer=0.
//  req_ready = (state==IDLE) & ~flush_i. It is therefore 1 out of reset when flush_i=0.
//  Accept in cycle T: latch haddr. Word count k = haddr[0] ? 3 : 2. Base word W = haddr[PC_W-1:1].
//  States: IDLE -> ISSUE (k cycles) -> DRAIN (1 cycle) -> RESP -> IDLE.
//  ISSUE: mem_rd=1, mem_addr = W+i, i=0..k-1, in cycles T+1..T+k. W+i wraps modulo 2^WA_W.
//  Capture mem_rdata into 3x32 buffer slot i at the end of cycle T+i+2 (one cycle after its mem_rd).
//  DRAIN waits for the last beat. rsp_valid rises in cycle T+k+2: T+4 aligned, T+5 offset.
//  rsp_data = haddr[0] ? {w2,w1,w0}[79:16] : {w1,w0}. It is registered and stable while rsp_valid.
//  RESP: hold rsp_valid/rsp_data/rsp_haddr until rsp_ready. On handshake, rsp_valid=0 and IDLE
//  next cycle. No request is accepted in the handshake cycle. Minimum back-to-back spacing is 1 IDLE cycle.
//  rsp_valid never drops without a handshake, except on flush_i or reset.
//  flush_i (any state, highest priority): next cycle IDLE, rsp_valid=0, mem_rd=0.
//  Beats still returning on mem_rdata are ignored. A concurrent req_valid is not accepted.
//  flush_i in RESP together with rsp_ready: the flush wins and the response is treated as not delivered.
//  mem_rd=0 in every state except ISSUE. mem_addr holds its last value when idle.
//  rst_n asserted mid-fetch: immediate return to reset values. No partial response after release.
// STRUCTURE
//  Shared package v850_fetch_pkg holds:
//   - fetch_state_e {IDLE, ISSUE, DRAIN, RESP}
//   - FETCH_W=64, IMEM_DW=32
//   - function beats(haddr0) returning 2 or 3
//  Sub-module imem_window_align (combinational): 96-bit buffer + haddr[0] -> 64-bit window.
//  FSM, beat counter and capture registers stay in this module.
// TESTING (RAM word0=0x125F11C1, w1=0x1EC12141, w2=0x49E1000B, w3=0x125F11C1, w4=0)
//  1 haddr=0 accepted T -> mem_addr 0,1 at T+1,T+2; rsp_valid T+4, rsp_data=0x1EC12141_125F11C1.
//  2 haddr=1 -> reads 0,1,2; rsp_valid T+5, rsp_data=0x000B1EC1_2141125F.
//  3 haddr=3 -> reads 1,2,3; rsp_data=0x11C149E1_000B1EC1. Then rsp_ready=0 for 3 cycles:
//    rsp_valid/rsp_data stable, req_ready=0; IDLE the cycle after handshake.
//  4 flush_i at T+2 of haddr=1 fetch -> no rsp_valid, mem_rd=0 from T+3; next req haddr=0
//    returns 0x1EC12141_125F11C1 uncorrupted by stale beats.
//  5 haddr=0x1FFFFFF -> mem_addr 0xFFFFFF,0x000000,0x000001; window = bytes of those words [79:16].
//  6 rst_n low during ISSUE and during RESP -> all outputs at reset values at once;
//    req_ready=1 the cycle after release.

Source files
------------

// File: rtl/v850_fetch_pkg.sv
// rtl/v850_fetch_pkg.sv - shared types and helpers for the instruction fetch path
//
// Purpose: the state encoding, bus widths and beat-count helper used by the
// instruction-memory fetch responder and its window aligner.
// Ports: none (package).

package v850_fetch_pkg;

  localparam int FETCH_W = 64;  // fetch window returned to the fetcher
  localparam int IMEM_DW = 32;  // instruction RAM data width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } fetch_state_e;

  // A halfword-offset window straddles one extra RAM word.
  function automatic logic [1:0] beats(input logic haddr0);
    return haddr0 ? 2'd3 : 2'd2;
  endfunction

endpackage

// File: rtl/imem_window_align.sv
// rtl/imem_window_align.sv - selects the 64-bit fetch window from three buffered RAM words
//
// Purpose: combinational byte alignment of the fetch window.
// Ports:
//   win_buf   in   96  {w2,w1,w0}, w0 holds the lowest-addressed bytes
//   half_off  in   1   window starts at a halfword offset inside w0
//   window    out  64  little-endian window, first byte in bits [7:0]

module imem_window_align
  import v850_fetch_pkg::*;
(
  input  logic [3*IMEM_DW-1:0] win_buf,
  input  logic                 half_off,
  output logic [FETCH_W-1:0]   window
);

  // Offset window skips the two low bytes of w0: bits [79:16], else [63:0].
  logic [4:0] bit_ofs;

  assign bit_ofs = {half_off, 4'b0000};
  assign window  = win_buf[bit_ofs +: FETCH_W];

endmodule

// File: rtl/imem_fetch_responder.sv
// rtl/imem_fetch_responder.sv - assembles 64-bit instruction fetch windows from a 32-bit sync RAM
//
// Purpose: accepts a halfword fetch address, reads 2 (aligned) or 3 (halfword
// offset) consecutive RAM words, and returns the 64-bit little-endian window
// starting at byte {haddr,1'b0}. flush_i aborts any fetch in progress.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   flush_i                abort in-flight fetch (highest priority)
//   req_valid/req_ready    request handshake, req_haddr = halfword address
//   rsp_valid/rsp_ready    response handshake, rsp_data = window, rsp_haddr = echo
//   mem_rd/mem_addr        RAM read strobe and word address
//   mem_rdata              RAM data, valid the cycle after mem_rd

module imem_fetch_responder
  import v850_fetch_pkg::*;
#(
  parameter  int PC_W = 25,
  localparam int WA_W = PC_W - 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  input  logic                 req_valid,
  input  logic [PC_W-1:0]      req_haddr,
  output logic                 req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [FETCH_W-1:0]   rsp_data,
  output logic [PC_W-1:0]      rsp_haddr,
  output logic                 mem_rd,
  output logic [WA_W-1:0]      mem_addr,
  input  logic [IMEM_DW-1:0]   mem_rdata
);

  fetch_state_e         state;
  logic [PC_W-1:0]      haddr_q;
  logic [1:0]           cnt;       // beats issued so far for this fetch
  logic                 rd_q;      // a beat is arriving on mem_rdata this cycle
  logic [1:0]           slot_q;    // buffer slot that beat belongs to
  logic [3*IMEM_DW-1:0] buffer;
  logic [3*IMEM_DW-1:0] buf_next;
  logic [FETCH_W-1:0]   window;

  assign req_ready = (state == IDLE) & ~flush_i;

  // Buffer including the beat landing this cycle, so DRAIN can register the
  // response in the same cycle the last word arrives.
  always_comb begin
    buf_next = buffer;
    if (rd_q) begin
      case (slot_q)
        2'd0:    buf_next[31:0]  = mem_rdata;
        2'd1:    buf_next[63:32] = mem_rdata;
        default: buf_next[95:64] = mem_rdata;
      endcase
    end
  end

  imem_window_align u_align (
    .win_buf  (buf_next),
    .half_off (haddr_q[0]),
    .window   (window)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      haddr_q   <= '0;
      cnt       <= '0;
      rd_q      <= 1'b0;
      slot_q    <= '0;
      buffer    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_haddr <= '0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
    end else begin
      rd_q   <= mem_rd;
      slot_q <= cnt - 2'd1;
      buffer <= buf_next;

      if (flush_i) begin
        // Beats already in flight are dropped by clearing rd_q.
        state     <= IDLE;
        rsp_valid <= 1'b0;
        mem_rd    <= 1'b0;
        rd_q      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (req_valid) begin
              haddr_q  <= req_haddr;
              mem_rd   <= 1'b1;
              mem_addr <= req_haddr[PC_W-1:1];
              cnt      <= 2'd1;
              state    <= ISSUE;
            end
          end
          ISSUE: begin
            if (cnt == beats(haddr_q[0])) begin
              mem_rd <= 1'b0;
              state  <= DRAIN;
            end else begin
              mem_addr <= mem_addr + 1'b1;  // wraps modulo 2^WA_W
              cnt      <= cnt + 2'd1;
            end
          end
          DRAIN: begin
            rsp_valid <= 1'b1;
            rsp_data  <= window;
            rsp_haddr <= haddr_q;
            state     <= RESP;
          end
          RESP: begin
            if (rsp_ready) begin
              rsp_valid <= 1'b0;
              state     <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// tb/tb_imem_fetch_responder.sv - scoreboard bench for imem_fetch_responder

module tb_imem_fetch_responder;

  localparam int PC_W = 25;
  localparam int WA_W = 24;

  logic            clk;
  logic            rst_n;
  logic            flush_i;
  logic            req_valid;
  logic [PC_W-1:0] req_haddr;
  logic            req_ready;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [63:0]     rsp_data;
  logic [PC_W-1:0] rsp_haddr;
  logic            mem_rd;
  logic [WA_W-1:0] mem_addr;
  logic [31:0]     mem_rdata;

  imem_fetch_responder #(.PC_W(PC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (flush_i),
    .req_valid (req_valid),
    .req_haddr (req_haddr),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_haddr (rsp_haddr),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [WA_W-1:0] addr_q[$];
  logic [63:0]     data_q[$];
  logic [PC_W-1:0] hq[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ram_word(input logic [WA_W-1:0] a);
    case (a)
      24'd0:   return 32'h125F11C1;
      24'd1:   return 32'h1EC12141;
      24'd2:   return 32'h49E1000B;
      24'd3:   return 32'h125F11C1;
      24'd4:   return 32'h00000000;
      default: return {~a[7:0], a};
    endcase
  endfunction

  function automatic logic [63:0] exp_win(input logic [PC_W-1:0] ha);
    logic [WA_W-1:0] w;
    logic [95:0]     b;
    w = ha[PC_W-1:1];
    b = {ram_word(w + 24'd2), ram_word(w + 24'd1), ram_word(w)};
    if (ha[0]) b = b >> 16;
    return b[63:0];
  endfunction

  // Synchronous-read RAM model; garbage when not reading.
  always @(posedge clk) mem_rdata <= mem_rd ? ram_word(mem_addr) : 32'h5A5A5A5A;

  always @(negedge clk) begin
    if (rst_n && mem_rd) begin
      if (addr_q.size() == 0) chk("mem_rd_extra", 1, 0);
      else chk("mem_addr", mem_addr, addr_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_fetch(input logic [PC_W-1:0] ha, input logic [63:0] expd, input bit push);
    int n;
    logic [WA_W-1:0] w;
    n = 0;
    req_valid = 1'b1;
    req_haddr = ha;
    while (!req_ready && n < 20) begin tick(); n++; end
    chk("req_ready_wait", req_ready, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    w = ha[PC_W-1:1];
    for (int i = 0; i < (ha[0] ? 3 : 2); i++) addr_q.push_back(w + i[WA_W-1:0]);
    if (push) begin
      data_q.push_back(expd);
      hq.push_back(ha);
    end
  endtask

  task automatic wait_rsp(input int lat);
    int n;
    n = 1;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    chk("rsp_latency", n, lat);
  endtask

  task automatic finish_rsp(input int hold);
    logic [63:0] d0;
    d0 = rsp_data;
    for (int i = 0; i < hold; i++) begin
      rsp_ready = 1'b0;
      tick();
      chk("hold_valid", rsp_valid, 1);
      chk("hold_data", rsp_data, d0);
      chk("hold_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    if (data_q.size() == 0) chk("sb_empty", 1, 0);
    else begin
      chk("rsp_data", rsp_data, data_q.pop_front());
      chk("rsp_haddr", rsp_haddr, hq.pop_front());
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", rsp_valid, 0);
    chk("idle_req_ready", req_ready, 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_rsp_haddr"}, rsp_haddr, 0);
    chk({tag, "_mem_rd"}, mem_rd, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
  endtask

  task automatic quiet(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      seen = seen | rsp_valid | mem_rd;
    end
    chk(tag, seen, 0);
  endtask

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; req_valid = 1'b0; req_haddr = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst_n = 1'b1;
    chk("reset_req_ready", req_ready, 1);

    // 1: aligned
    start_fetch(25'd0, 64'h1EC12141_125F11C1, 1'b1);
    wait_rsp(4);
    finish_rsp(0);

    // 2: halfword offset
    start_fetch(25'd1, 64'h000B1EC1_2141125F, 1'b1);
    wait_rsp(5);
    finish_rsp(0);

    // 3: offset, consumer stalls
    start_fetch(25'd3, 64'h11C149E1_000B1EC1, 1'b1);
    wait_rsp(5);
    finish_rsp(3);

    // 4: flush at T+2 of an offset fetch
    start_fetch(25'd1, 64'd0, 1'b0);
    tick();
    flush_i = 1'b1;
    chk("flush_req_ready", req_ready, 0);
    tick();
    flush_i = 1'b0;
    addr_q.delete();
    chk("flush_mem_rd", mem_rd, 0);
    chk("flush_rsp_valid", rsp_valid, 0);
    quiet("flush_quiet", 6);
    start_fetch(25'd0, 64'h1EC12141_125F11C1, 1'b1);
    wait_rsp(4);
    finish_rsp(1);

    // 5: wrap at top of word space
    start_fetch(25'h1FFFFFF, exp_win(25'h1FFFFFF), 1'b1);
    wait_rsp(5);
    finish_rsp(0);

    // 6a: reset during ISSUE
    start_fetch(25'd2, 64'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    addr_q.delete();
    chk_reset_vals("rst_issue");
    tick();
    rst_n = 1'b1;
    chk("rst_issue_req_ready", req_ready, 1);
    quiet("rst_issue_quiet", 6);

    // 6b: reset during RESP
    start_fetch(25'd1, 64'd0, 1'b0);
    wait_rsp(5);
    rst_n = 1'b0;
    #1;
    addr_q.delete();
    chk_reset_vals("rst_resp");
    tick();
    rst_n = 1'b1;
    chk("rst_resp_req_ready", req_ready, 1);
    quiet("rst_resp_quiet", 6);

    // recovery: aligned at word 1
    start_fetch(25'd2, 64'h49E1000B_1EC12141, 1'b1);
    wait_rsp(4);
    finish_rsp(0);

    chk("sb_leftover", data_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
